// File: rtl/ntt_job_arbiter_pkg.sv
//==============================================================================
// Module   : ntt_arb_pkg
// Brief    : Shared state encoding, address-width helper and defaults for
//            the ntt_job_arbiter slice.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package ntt_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } arb_state_t;

    localparam int c_TIMEOUT_CYCLES = 4096;

    // Wrapper address buses are never narrower than 10 bits.
    function automatic int ntt_aw(input int logn);
        return ((logn < 9) ? 9 : logn) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_job_arbiter_if.sv
//==============================================================================
// Module   : ntt_req_if / ntt_core_if
// Brief    : Requester job+memory bundle and shared NTT wrapper bundle.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface ntt_req_if #(
    parameter int LOGQ = 64,
    parameter int AW   = 10
);
    logic            valid;
    logic            intt;
    logic            btf_gs;
    logic            ready;
    logic            done;
    logic [AW-1:0]   rd_addr;
    logic [AW-1:0]   wr_addr;
    logic            wea;
    logic [LOGQ-1:0] dout0;
    logic [LOGQ-1:0] dout1;
    logic [LOGQ-1:0] din0;
    logic [LOGQ-1:0] din1;

    // master = job source / coefficient memory, slave = arbiter
    modport master (
        output valid, intt, btf_gs, din0, din1,
        input  ready, done, rd_addr, wr_addr, wea, dout0, dout1
    );
    modport slave (
        input  valid, intt, btf_gs, din0, din1,
        output ready, done, rd_addr, wr_addr, wea, dout0, dout1
    );
endinterface

interface ntt_core_if #(
    parameter int LOGQ = 64,
    parameter int AW   = 10
);
    logic            start;
    logic            intt;
    logic            btf_gs;
    logic [AW-1:0]   read_address;
    logic [AW-1:0]   write_address;
    logic            wea;
    logic [LOGQ-1:0] din0;
    logic [LOGQ-1:0] din1;
    logic [LOGQ-1:0] dout0;
    logic [LOGQ-1:0] dout1;
    logic            finish;

    // master = arbiter, slave = ntt_memory_wrapper
    modport master (
        output start, intt, btf_gs, din0, din1,
        input  read_address, write_address, wea, dout0, dout1, finish
    );
    modport slave (
        input  start, intt, btf_gs, din0, din1,
        output read_address, write_address, wea, dout0, dout1, finish
    );
endinterface

`default_nettype wire

// File: rtl/ntt_job_arbiter_rr2.sv
//==============================================================================
// Module   : ntt_arb_rr2
// Brief    : Two-way round-robin picker; a tie goes to the requester that
//            did not own the previous job.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ntt_arb_rr2 (
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic       o_grant,
    output logic       o_any
);

    always_comb begin
        o_any   = |i_valid;
        o_grant = 1'b0;
        case (i_valid)
            2'b10:   o_grant = 1'b1;
            2'b11:   o_grant = ~i_last;
            default: o_grant = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ntt_job_arbiter.sv
//==============================================================================
// Module   : ntt_job_arbiter
// Brief    : Shares one NTT memory wrapper between two job requesters and
//            steers the wrapper memory buses to the owner's memory.
//            Optional watchdog: define NTT_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ntt_job_arbiter
    import ntt_arb_pkg::*;
#(
    parameter int LOGQ           = 64,
    parameter int LOGN           = 4,
    parameter int AW             = ntt_aw(LOGN),
    parameter int TIMEOUT_CYCLES = c_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    ntt_req_if.slave   req0,
    ntt_req_if.slave   req1,
    ntt_core_if.master ntt,
    output logic       busy,
    output logic       owner,
    output logic       err
);

    localparam logic [AW-1:0]   c_ADDR_ZERO = '0;
    localparam logic [LOGQ-1:0] c_DATA_ZERO = '0;

    arb_state_t state_q, state_d;
    logic owner_q, owner_d;
    logic last_q, last_d;
    logic intt_q, intt_d;
    logic btf_q, btf_d;
    logic start_q, start_d;
    logic fin_q, fin_d;
    logic err_q, err_d;
    logic w_pick, w_any, w_fin_edge, w_timeout;

    ntt_arb_rr2 u_rr2 (
        .i_valid ({req1.valid, req0.valid}),
        .i_last  (last_q),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

    // A finish that is already high when RUN starts produces no edge here.
    assign w_fin_edge = ntt.finish & ~fin_q;

`ifdef NTT_ARB_TIMEOUT_EN
    localparam int c_CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_GRANT) begin
            cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            cnt_d = cnt_q + c_CW'(1);
        end
    end

    assign w_timeout = (state_q == ST_RUN) && (cnt_d == c_CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    wire unused_timeout_cycles = (TIMEOUT_CYCLES == 0);
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        intt_d  = intt_q;
        btf_d   = btf_q;
        start_d = 1'b0;
        err_d   = 1'b0;
        fin_d   = ntt.finish;
        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    owner_d = w_pick;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                intt_d  = owner_q ? req1.intt   : req0.intt;
                btf_d   = owner_q ? req1.btf_gs : req0.btf_gs;
                last_d  = owner_q;
                start_d = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (w_fin_edge) begin
                    state_d = ST_DONE;
                end else if (w_timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    start_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            intt_q  <= 1'b0;
            btf_q   <= 1'b0;
            start_q <= 1'b0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            intt_q  <= intt_d;
            btf_q   <= btf_d;
            start_q <= start_d;
            fin_q   <= fin_d;
            err_q   <= err_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign owner      = owner_q;
    assign err        = err_q;
    assign ntt.start  = start_q;
    assign ntt.intt   = intt_q;
    assign ntt.btf_gs = btf_q;
    assign req0.ready = (state_q == ST_GRANT) && !owner_q;
    assign req1.ready = (state_q == ST_GRANT) &&  owner_q;
    assign req0.done  = (state_q == ST_DONE)  && !owner_q;
    assign req1.done  = (state_q == ST_DONE)  &&  owner_q;

    // Routing follows the owner from GRANT through GAP so trailing writes land.
    always_comb begin
        req0.rd_addr = c_ADDR_ZERO;
        req0.wr_addr = c_ADDR_ZERO;
        req0.wea     = 1'b0;
        req0.dout0   = c_DATA_ZERO;
        req0.dout1   = c_DATA_ZERO;
        req1.rd_addr = c_ADDR_ZERO;
        req1.wr_addr = c_ADDR_ZERO;
        req1.wea     = 1'b0;
        req1.dout0   = c_DATA_ZERO;
        req1.dout1   = c_DATA_ZERO;
        ntt.din0     = c_DATA_ZERO;
        ntt.din1     = c_DATA_ZERO;
        if (busy) begin
            if (owner_q) begin
                req1.rd_addr = ntt.read_address;
                req1.wr_addr = ntt.write_address;
                req1.wea     = ntt.wea;
                req1.dout0   = ntt.dout0;
                req1.dout1   = ntt.dout1;
                ntt.din0     = req1.din0;
                ntt.din1     = req1.din1;
            end else begin
                req0.rd_addr = ntt.read_address;
                req0.wr_addr = ntt.write_address;
                req0.wea     = ntt.wea;
                req0.dout0   = ntt.dout0;
                req0.dout1   = ntt.dout1;
                ntt.din0     = req0.din0;
                ntt.din1     = req0.din1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ntt_job_arbiter.sv
//==============================================================================
// Module   : tb_ntt_job_arbiter
// Brief    : Self-checking bench for ntt_job_arbiter (job-timeline model).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ntt_job_arbiter;

    localparam int LOGQ = 64;
    localparam int LOGN = 4;
    localparam int AW   = 10;
`ifdef NTT_ARB_TIMEOUT_EN
    localparam int TO    = 16;
    localparam int B_RUN = 10;
`else
    localparam int TO    = 4096;
    localparam int B_RUN = 40;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, owner, err;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_on = 1'b0;
    bit   bus_rand = 1'b1;
    bit   s0, s1;

    ntt_req_if  #(.LOGQ(LOGQ), .AW(AW)) req0 ();
    ntt_req_if  #(.LOGQ(LOGQ), .AW(AW)) req1 ();
    ntt_core_if #(.LOGQ(LOGQ), .AW(AW)) core ();

    ntt_job_arbiter #(.LOGQ(LOGQ), .LOGN(LOGN), .AW(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .req1  (req1),
        .ntt   (core),
        .busy  (busy),
        .owner (owner),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Job-timeline model: a job is (owner, age since grant, age of its DONE cycle).
    bit m_on = 0, m_owner = 0, m_last = 1, m_intt = 0, m_btf = 0, m_pf = 0, m_to = 0;
    int m_age = 0;
    int m_end = -1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_on = 0; m_owner = 0; m_last = 1; m_intt = 0; m_btf = 0;
            m_pf = 0; m_to = 0; m_age = 0; m_end = -1;
        end else begin
            if (!m_on) begin
                if (req0.valid || req1.valid) begin
                    m_owner = (req0.valid && req1.valid) ? !m_last : req1.valid;
                    m_on = 1; m_age = 0; m_end = -1; m_to = 0;
                end
            end else begin
                if (m_age == 0) begin
                    m_intt = m_owner ? req1.intt   : req0.intt;
                    m_btf  = m_owner ? req1.btf_gs : req0.btf_gs;
                    m_last = m_owner;
                end else if (m_end < 0) begin
                    if (core.finish && !m_pf) m_end = m_age + 1;
`ifdef NTT_ARB_TIMEOUT_EN
                    else if (m_age == TO) begin m_end = m_age + 1; m_to = 1; end
`endif
                end
                if (m_end >= 0 && m_age == m_end + 1) m_on = 0;
                else m_age++;
            end
            m_pf = core.finish;
        end
    end

    logic e_grant, e_run, e_done, e_r0, e_r1;
    assign e_grant = m_on && m_age == 0;
    assign e_run   = m_on && m_age >= 1 && m_end < 0;
    assign e_done  = m_on && m_end >= 0 && m_age == m_end;
    assign e_r0    = m_on && !m_owner;
    assign e_r1    = m_on &&  m_owner;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy",   64'(busy),        64'(m_on));
            chk("owner",  64'(owner),       64'(m_owner));
            chk("start",  64'(core.start),  64'(e_run));
            chk("intt",   64'(core.intt),   64'(m_intt));
            chk("btf_gs", 64'(core.btf_gs), 64'(m_btf));
            chk("ready0", 64'(req0.ready),  64'(e_grant && !m_owner));
            chk("ready1", 64'(req1.ready),  64'(e_grant &&  m_owner));
            chk("done0",  64'(req0.done),   64'(e_done && !m_owner));
            chk("done1",  64'(req1.done),   64'(e_done &&  m_owner));
            chk("err",    64'(err),         64'(e_done && m_to));
            chk("mem0_rd",  64'(req0.rd_addr), e_r0 ? 64'(core.read_address)  : 64'd0);
            chk("mem0_wr",  64'(req0.wr_addr), e_r0 ? 64'(core.write_address) : 64'd0);
            chk("mem0_wea", 64'(req0.wea),     e_r0 ? 64'(core.wea)           : 64'd0);
            chk("mem0_d0",  req0.dout0,        e_r0 ? core.dout0              : 64'd0);
            chk("mem0_d1",  req0.dout1,        e_r0 ? core.dout1              : 64'd0);
            chk("mem1_rd",  64'(req1.rd_addr), e_r1 ? 64'(core.read_address)  : 64'd0);
            chk("mem1_wr",  64'(req1.wr_addr), e_r1 ? 64'(core.write_address) : 64'd0);
            chk("mem1_wea", 64'(req1.wea),     e_r1 ? 64'(core.wea)           : 64'd0);
            chk("mem1_d0",  req1.dout0,        e_r1 ? core.dout0              : 64'd0);
            chk("mem1_d1",  req1.dout1,        e_r1 ? core.dout1              : 64'd0);
            chk("ntt_din0", core.din0, e_r1 ? req1.din0 : (e_r0 ? req0.din0 : 64'd0));
            chk("ntt_din1", core.din1, e_r1 ? req1.din1 : (e_r0 ? req0.din1 : 64'd0));
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (bus_rand) begin
                core.read_address  = AW'($urandom);
                core.write_address = AW'($urandom);
                core.wea           = 1'($urandom);
                core.dout0 = {$urandom, $urandom};
                core.dout1 = {$urandom, $urandom};
                req0.din0  = {$urandom, $urandom};
                req0.din1  = {$urandom, $urandom};
                req1.din0  = {$urandom, $urandom};
                req1.din1  = {$urandom, $urandom};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic wait_ready(input bit k, input int lim);
        bit got = 0;
        for (int i = 0; i < lim && !got; i++) begin
            @(negedge clk);
            got = k ? req1.ready : req0.ready;
        end
        chk(k ? "grant1_wait" : "grant0_wait", 64'(got), 64'd1);
    endtask

    // Called in RUN; returns one step after the arbiter is back in IDLE.
    task automatic pulse_finish();
        @(posedge clk); #1 core.finish = 1'b1;
        @(posedge clk); #1 core.finish = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        bit g;
        bit got;
        req0.valid = 0; req0.intt = 0; req0.btf_gs = 0;
        req1.valid = 0; req1.intt = 0; req1.btf_gs = 0;
        core.finish = 0; core.wea = 0; core.read_address = '0; core.write_address = '0;
        core.dout0 = '0; core.dout1 = '0;
        req0.din0 = '0; req0.din1 = '0; req1.din0 = '0; req1.din1 = '0;
        #2 rst = 1'b0; chk_on = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_start", 64'(core.start), 64'd0);
        chk("rst_err",   64'(err), 64'd0);

        // Single job on requester 0
        @(posedge clk); #1 req0.valid = 1; req0.intt = 0; req0.btf_gs = 1;
        @(negedge clk); chk("ready0_early", 64'(req0.ready), 64'd0);
        @(negedge clk); chk("ready0_grant", 64'(req0.ready), 64'd1);
        @(posedge clk); #1 req0.valid = 0;
        @(negedge clk);
        chk("start_run1", 64'(core.start), 64'd1);
        chk("btf_latch",  64'(core.btf_gs), 64'd1);
        chk("intt_latch", 64'(core.intt), 64'd0);
        repeat (B_RUN) @(posedge clk);
        #1 core.finish = 1;
        @(posedge clk); #1 core.finish = 0;
        @(negedge clk);
        chk("single_done0", 64'(req0.done), 64'd1);
        chk("single_start", 64'(core.start), 64'd0);
        chk("single_owner", 64'(owner), 64'd0);
        repeat (3) @(posedge clk);

        // Tie at reset exit: grants must alternate 0,1,0,1
        #1 rst = 0;
        req0.valid = 1; req0.intt = 0; req1.valid = 1; req1.intt = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        for (int j = 0; j < 4; j++) begin
            got = 0; g = 0;
            for (int i = 0; i < 8 && !got; i++) begin
                @(negedge clk);
                got = req0.ready | req1.ready;
                g = req1.ready;
            end
            chk("tie_wait",  64'(got), 64'd1);
            chk("tie_order", 64'(g), 64'(j % 2));
            @(negedge clk); chk("tie_intt", 64'(core.intt), 64'(j % 2));
            @(posedge clk); #1 core.finish = 1;
            @(posedge clk); #1 core.finish = 0;
            if (j == 3) begin req0.valid = 0; req1.valid = 0; end
            @(posedge clk);
            @(posedge clk); #1;
        end

        // Routing during an owner-1 job
        req1.valid = 1; req1.intt = 1; req1.btf_gs = 0;
        wait_ready(1, 8);
        @(posedge clk); #1 req1.valid = 0;
        bus_rand = 0; core.wea = 1; core.write_address = AW'(5); core.dout0 = 64'hABCD;
        @(negedge clk);
        chk("route_wea1",  64'(req1.wea), 64'd1);
        chk("route_addr1", 64'(req1.wr_addr), 64'd5);
        chk("route_dout1", req1.dout0, 64'hABCD);
        chk("route_wea0",  64'(req0.wea), 64'd0);
        bus_rand = 1;
        pulse_finish();

        // Reset in RUN cycle 10 with requester 1 pending
        req0.valid = 1;
        wait_ready(0, 8);
        @(posedge clk); #1 req0.valid = 0; req1.valid = 1;
        repeat (9) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("mrst_start", 64'(core.start), 64'd0);
        chk("mrst_busy",  64'(busy), 64'd0);
        chk("mrst_done",  64'(req0.done | req1.done), 64'd0);
        @(posedge clk); @(posedge clk); #1 rst = 1;
        wait_ready(1, 8);
        chk("mrst_owner", 64'(owner), 64'd1);
        @(posedge clk); #1 req1.valid = 0;
        pulse_finish();

        // Finish already high on RUN entry
        core.finish = 1; req0.valid = 1;
        wait_ready(0, 8);
        @(posedge clk); #1 req0.valid = 0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("held_start", 64'(core.start), 64'd1);
        chk("held_done",  64'(req0.done), 64'd0);
        @(posedge clk); #1 core.finish = 0;
        @(posedge clk); #1 core.finish = 1;
        @(posedge clk); #1 core.finish = 0;
        @(negedge clk); chk("held_done0", 64'(req0.done), 64'd1);
        repeat (3) @(posedge clk);

`ifdef NTT_ARB_TIMEOUT_EN
        #1 req0.valid = 1;
        wait_ready(0, 8);
        @(posedge clk); #1 req0.valid = 0;
        n = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            n++;
            got = req0.done;
        end
        chk("to_cycles", 64'(n), 64'd17);
        chk("to_err",    64'(err), 64'd1);
        repeat (3) @(posedge clk);
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); s0 = req0.ready; s1 = req1.ready;
            @(posedge clk); #1;
            if (req0.valid && s0) begin
                req0.valid = 0; req0.intt = 1'($urandom); req0.btf_gs = 1'($urandom);
            end else if (!req0.valid && $urandom_range(0, 3) == 0) begin
                req0.valid = 1; req0.intt = 1'($urandom); req0.btf_gs = 1'($urandom);
            end else if (req0.valid && $urandom_range(0, 40) == 0) begin
                req0.valid = 0;
            end
            if (req1.valid && s1) begin
                req1.valid = 0; req1.intt = 1'($urandom); req1.btf_gs = 1'($urandom);
            end else if (!req1.valid && $urandom_range(0, 3) == 0) begin
                req1.valid = 1; req1.intt = 1'($urandom); req1.btf_gs = 1'($urandom);
            end else if (req1.valid && $urandom_range(0, 40) == 0) begin
                req1.valid = 0;
            end
            if ($urandom_range(0, 7) == 0) core.finish = !core.finish;
        end
        req0.valid = 0; req1.valid = 0;
        repeat (10) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
